counter_control_mc: RTL and testbench

//  Multi-channel count-enable generator for the APB timer counter path.

---
 rtl/counter_control_mc_if.sv | 37 +++
 rtl/counter_control_mc.sv | 79 +++++++
 tb/tb_counter_control_mc.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_control_mc_if.sv
// Per-channel control and count-enable bundle for counter_control_mc.
// master drives configuration; slave returns pulses and status.
interface counter_control_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       timer_en;
  logic [NUM_CH-1:0]       div_en;
  logic [NUM_CH-1:0]       div_mode;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       halt_ack;
  logic                    sync_clr;
  logic [NUM_CH-1:0]       cnt_en;
  logic [NUM_CH-1:0]       cfg_rst;

  modport master (
    output timer_en,
    output div_en,
    output div_mode,
    output div_val,
    output halt_ack,
    output sync_clr,
    input  cnt_en,
    input  cfg_rst
  );

  modport slave (
    input  timer_en,
    input  div_en,
    input  div_mode,
    input  div_val,
    input  halt_ack,
    input  sync_clr,
    output cnt_en,
    output cfg_rst
  );
endinterface

// File: rtl/counter_control_mc.sv
// Multi-channel count-enable generator for the timer counter path.
// Each channel divides CLK by 2**e (pow2) or div_val+1 (linear).
module counter_control_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DVAL_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  counter_control_mc_if.slave  bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]  dv;
    logic [DVAL_W-1:0] e;
    logic [CNT_W-1:0]  term;
    logic [CNT_W-1:0]  term_q;
    logic [CNT_W-1:0]  int_cnt;
    logic              cfg_chg;
    logic              cfg_q;
    logic              ce;
    logic              at_term;
    int                sh;

    assign dv = bus.div_val[i*CNT_W +: CNT_W];
    assign e  = dv[DVAL_W-1:0];

    always_comb begin
      sh = 32'(e);
      if (sh >= CNT_W) sh = CNT_W - 1;
      if (bus.div_mode[i]) term = dv;
      else term = ~({CNT_W{1'b1}} << sh);
    end

    assign at_term = (int_cnt == term);
    assign cfg_chg = (term != term_q)
                   & bus.timer_en[i]
                   & bus.div_en[i];

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        int_cnt <= '0;
        term_q  <= '0;
        cfg_q   <= 1'b0;
      end else begin
        term_q <= term;
        cfg_q  <= cfg_chg;
        // restart beats halt so a reconfig is never lost
        if (!bus.timer_en[i] || !bus.div_en[i])
          int_cnt <= '0;
        else if (bus.sync_clr || cfg_chg)
          int_cnt <= '0;
        else if (bus.halt_ack[i])
          int_cnt <= int_cnt;
        else if (at_term)
          int_cnt <= '0;
        else
          int_cnt <= int_cnt + 1'b1;
      end
    end

    always_comb begin
      ce = 1'b0;
      if (!bus.timer_en[i])
        ce = 1'b0;
      else if (!bus.div_en[i])
        ce = ~bus.halt_ack[i];
      else
        ce = at_term
           & ~bus.halt_ack[i]
           & ~bus.sync_clr
           & ~cfg_chg;
    end

    assign bus.cnt_en[i]  = ce;
    assign bus.cfg_rst[i] = cfg_q;
  end

endmodule

// File: tb/tb_counter_control_mc.sv
// Scoreboard bench for counter_control_mc: stimulus queues expected
// pulse/status events, a negedge monitor pops and compares them.
module tb_counter_control_mc;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  counter_control_mc_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  counter_control_mc #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .DVAL_W(4)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int         c;
    logic [3:0] ce;
    logic [3:0] cr;
  } ev_t;

  ev_t q[$];

  task automatic push(int c, logic [3:0] ce, logic [3:0] cr);
    ev_t e;
    e.c  = c;
    e.ce = ce;
    e.cr = cr;
    q.push_back(e);
  endtask

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic setcfg(int ch, logic den, logic md, logic [15:0] dv);
    bus.div_en[ch]          = den;
    bus.div_mode[ch]        = md;
    bus.div_val[ch*CW +: CW] = dv;
    tick(1);
  endtask

  task automatic drain(string nm);
    check(nm, q.size(), 0);
    q.delete();
  endtask

  task automatic run_one(string nm, int ch, int first, int period, int n);
    int c;
    logic [3:0] m;
    m = 4'(1 << ch);
    c = cyc;
    bus.timer_en[ch] = 1'b1;
    for (int k = 0; k < n; k++) push(c + first + k*period, m, 4'b0);
    tick(first + (n-1)*period + 1);
    bus.timer_en[ch] = 1'b0;
    tick(1);
    drain(nm);
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (bus.cnt_en != 4'b0 || bus.cfg_rst != 4'b0) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: cyc %0d cnt_en %b cfg_rst %b, none expected",
                 cyc, bus.cnt_en, bus.cfg_rst);
      end else begin
        e = q.pop_front();
        if (e.c == cyc && e.ce == bus.cnt_en && e.cr == bus.cfg_rst)
          n_pass++;
        else
          $display("FAIL event: got cyc %0d cnt_en %b cfg_rst %b, expected cyc %0d cnt_en %b cfg_rst %b",
                   cyc, bus.cnt_en, bus.cfg_rst, e.c, e.ce, e.cr);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    bus.timer_en = '0;
    bus.div_en   = '0;
    bus.div_mode = '0;
    bus.div_val  = '0;
    bus.halt_ack = '0;
    bus.sync_clr = 1'b0;
    tick(3);
    RST_N = 1'b1;
    check("rst_cnt_en", int'(bus.cnt_en), 0);
    check("rst_cfg_rst", int'(bus.cfg_rst), 0);

    setcfg(0, 1'b1, 1'b0, 16'd3);
    run_one("pow2_dv3", 0, 7, 8, 4);
    setcfg(0, 1'b1, 1'b0, 16'hfff3);
    run_one("pow2_hi_ignored", 0, 7, 8, 2);
    setcfg(0, 1'b1, 1'b1, 16'd4);
    run_one("lin_dv4", 0, 4, 5, 4);
    setcfg(0, 1'b1, 1'b1, 16'd0);
    run_one("lin_dv0", 0, 0, 1, 6);
    setcfg(1, 1'b1, 1'b0, 16'd15);
    run_one("pow2_dv15", 1, 32767, 32768, 1);

    setcfg(0, 1'b1, 1'b0, 16'd2);
    c = cyc;
    bus.timer_en[0] = 1'b1;
    tick(2);
    bus.halt_ack[0] = 1'b1;
    tick(10);
    bus.halt_ack[0] = 1'b0;
    push(c + 13, 4'b0001, 4'b0);
    push(c + 17, 4'b0001, 4'b0);
    tick(6);
    bus.timer_en[0] = 1'b0;
    tick(1);
    drain("halt");

    setcfg(0, 1'b1, 1'b1, 16'd7);
    c = cyc;
    bus.timer_en[0] = 1'b1;
    tick(3);
    bus.div_val[0 +: CW] = 16'd3;
    push(c + 4,  4'b0000, 4'b0001);
    push(c + 7,  4'b0001, 4'b0);
    push(c + 11, 4'b0001, 4'b0);
    push(c + 15, 4'b0001, 4'b0);
    tick(13);
    bus.timer_en[0] = 1'b0;
    tick(1);
    drain("cfg_change");

    for (int ch = 0; ch < NCH; ch++) setcfg(ch, 1'b1, 1'b1, 16'd5);
    c = cyc;
    bus.timer_en = 4'b0001;
    tick(1);
    bus.timer_en = 4'b0011;
    tick(1);
    bus.timer_en = 4'b0111;
    tick(1);
    bus.timer_en = 4'b1111;
    tick(2);
    bus.sync_clr = 1'b1;
    tick(1);
    bus.sync_clr = 1'b0;
    push(c + 11, 4'b1111, 4'b0);
    push(c + 17, 4'b1111, 4'b0);
    push(c + 23, 4'b1111, 4'b0);
    tick(18);
    bus.timer_en = 4'b0000;
    tick(1);
    drain("sync_clr");

    setcfg(0, 1'b1, 1'b1, 16'd7);
    c = cyc;
    bus.timer_en[0] = 1'b1;
    tick(2);
    bus.div_val[0 +: CW] = 16'd6;
    push(c + 3, 4'b0000, 4'b0001);
    tick(1);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    check("midrst_cfg_rst", int'(bus.cfg_rst), 0);
    push(c + 5,  4'b0000, 4'b0001);
    push(c + 11, 4'b0001, 4'b0);
    push(c + 18, 4'b0001, 4'b0);
    tick(15);
    bus.timer_en[0] = 1'b0;
    tick(1);
    drain("mid_reset");

    setcfg(0, 1'b0, 1'b0, 16'd0);
    setcfg(1, 1'b0, 1'b0, 16'd5);
    c = cyc;
    push(c,     4'b0010, 4'b0);
    push(c + 1, 4'b0010, 4'b0);
    bus.timer_en[1] = 1'b1;
    tick(1);
    bus.div_val[CW +: CW] = 16'd9;
    tick(1);
    bus.halt_ack[1] = 1'b1;
    tick(2);
    bus.halt_ack[1] = 1'b0;
    push(c + 4, 4'b0010, 4'b0);
    push(c + 5, 4'b0010, 4'b0);
    tick(2);
    bus.timer_en[1] = 1'b0;
    tick(1);
    drain("div_bypass");

    tick(2);
    drain("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
